// File: rtl/ups_axil_master.sv
// AXI4-Lite initiator: turns single-beat fabric register commands into one outstanding AXI4-Lite transaction.
// Define UPS_AXIL_MASTER_TIMEOUT_EN to build the stalled-handshake watchdog.
module ups_axil_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] ca4l_awaddr,
    output logic [2:0]  ca4l_awprot,
    output logic        ca4l_awvalid,
    input  logic        ca4l_awready,
    output logic [31:0] ca4l_wdata,
    output logic [3:0]  ca4l_wstrb,
    output logic        ca4l_wvalid,
    input  logic        ca4l_wready,
    input  logic [1:0]  ca4l_bresp,
    input  logic        ca4l_bvalid,
    output logic        ca4l_bready,
    output logic [31:0] ca4l_araddr,
    output logic [2:0]  ca4l_arprot,
    output logic        ca4l_arvalid,
    input  logic        ca4l_arready,
    input  logic [31:0] ca4l_rdata,
    input  logic [1:0]  ca4l_rresp,
    input  logic        ca4l_rvalid,
    output logic        ca4l_rready
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

    state_t state, state_nxt;
    logic   accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, any_hs;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("ups_axil_master: TIMEOUT must be at least 2");
    end

    assign cmd_ready   = (state == IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign aw_hs       = ca4l_awvalid & ca4l_awready;
    assign w_hs        = ca4l_wvalid & ca4l_wready;
    assign ar_hs       = ca4l_arvalid & ca4l_arready;
    assign b_hs        = ca4l_bvalid & ca4l_bready;
    assign r_hs        = ca4l_rvalid & ca4l_rready;
    assign any_hs      = aw_hs | w_hs | ar_hs | b_hs | r_hs;
    assign ca4l_awprot = 3'b000;
    assign ca4l_arprot = 3'b000;

`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_fire;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A channel whose valid has already dropped counts as done, so AW and W may finish in any order.
    always_comb begin
        state_nxt = state;
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
        wd_fire = 1'b0;
`endif
        case (state)
            IDLE:    if (accept) state_nxt = cmd_write ? WADDR : RADDR;
            WADDR:   if ((!ca4l_awvalid || ca4l_awready) && (!ca4l_wvalid || ca4l_wready))
                         state_nxt = WRESP;
            WRESP:   if (b_hs) state_nxt = IDLE;
            RADDR:   if (ar_hs) state_nxt = RDATA;
            RDATA:   if (r_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
        if (state != IDLE && state_nxt == state && !any_hs && wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            wd_fire   = 1'b1;
        end
`endif
    end

`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)                              wd_cnt <= '0;
        else if (state_nxt != state || any_hs) wd_cnt <= '0;
        else if (state != IDLE)               wd_cnt <= wd_cnt + 1'b1;
    end
`endif

    // Address/data/strobe only load in IDLE, so they stay stable while any valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            ca4l_awaddr <= cmd_addr;
            ca4l_araddr <= cmd_addr;
            ca4l_wdata  <= cmd_wdata;
            ca4l_wstrb  <= cmd_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ca4l_awvalid <= 1'b0;
            ca4l_wvalid  <= 1'b0;
            ca4l_arvalid <= 1'b0;
            ca4l_bready  <= 1'b0;
            ca4l_rready  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= '0;
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            rsp_valid   <= 1'b0;
            ca4l_bready <= (state_nxt == WRESP);
            ca4l_rready <= (state_nxt == RDATA);
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            if (accept) begin
                ca4l_awvalid <= cmd_write;
                ca4l_wvalid  <= cmd_write;
                ca4l_arvalid <= !cmd_write;
            end
            if (aw_hs) ca4l_awvalid <= 1'b0;
            if (w_hs)  ca4l_wvalid  <= 1'b0;
            if (ar_hs) ca4l_arvalid <= 1'b0;
            if (b_hs) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= ca4l_bresp;
            end
            if (r_hs) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= ca4l_rresp;
                rsp_rdata <= ca4l_rdata;
            end
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
            if (wd_fire) begin
                ca4l_awvalid <= 1'b0;
                ca4l_wvalid  <= 1'b0;
                ca4l_arvalid <= 1'b0;
                rsp_valid    <= 1'b1;
                rsp_timeout  <= 1'b1;
                rsp_resp     <= 2'b10;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ups_axil_master.sv
// Directed table-driven bench for ups_axil_master with hand-written watchdog and reset sequences.
module tb_ups_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ups_axil_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .ca4l_awaddr(awaddr), .ca4l_awprot(awprot), .ca4l_awvalid(awvalid), .ca4l_awready(awready),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready),
        .ca4l_bresp(bresp), .ca4l_bvalid(bvalid), .ca4l_bready(bready),
        .ca4l_araddr(araddr), .ca4l_arprot(arprot), .ca4l_arvalid(arvalid), .ca4l_arready(arready),
        .ca4l_rdata(rdata), .ca4l_rresp(rresp), .ca4l_rvalid(rvalid), .ca4l_rready(rready)
    );

    typedef struct {
        bit          write;
        bit          b2b;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          v_start;
        logic [1:0]  resp;
        logic [31:0] rdat;
        int          exp_rsp;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
        int          exp_rdy;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    endtask

    // Called at a negedge; that cycle is cycle 0 and the command is presented in it.
    task automatic run_txn(input vec_t v, input int idx);
        int rsp_cyc = -1, awc = 0, wc = 0, arc = 0, rdy_first = -1, bad = 0;
        logic [1:0]  got_resp = 2'bxx;
        logic [31:0] got_rdata = 32'hx;
        logic        got_to = 1'bx;
        check($sformatf("v%0d_cmd_ready", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdat; cmd_wstrb = v.strb;
        slave_idle();
        for (int t = 1; t <= 40 && rsp_cyc < 0; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                rsp_cyc = t; got_resp = rsp_resp; got_rdata = rsp_rdata; got_to = rsp_timeout;
            end
            if (awvalid) begin awc++; if (awaddr !== v.addr || awprot !== 3'b0) bad++; end
            if (wvalid)  begin wc++;  if (wdata !== v.wdat || wstrb !== v.strb) bad++; end
            if (arvalid) begin arc++; if (araddr !== v.addr || arprot !== 3'b0) bad++; end
            if ((bready || rready) && rdy_first < 0) rdy_first = t;
            awready = (t >= 1 + v.aw_dly);
            wready  = (t >= 1 + v.w_dly);
            arready = (t >= 1 + v.ar_dly);
            bvalid  = v.write && (t >= v.v_start) && (rsp_cyc < 0);
            rvalid  = !v.write && (t >= v.v_start) && (rsp_cyc < 0);
            bresp   = v.resp;
            rresp   = v.resp;
            rdata   = rvalid ? v.rdat : 32'hBAD0_BAD0;
        end
        slave_idle();
        check($sformatf("v%0d_rsp_cycle", idx), rsp_cyc, v.exp_rsp);
        check($sformatf("v%0d_rsp_resp", idx), {30'd0, got_resp}, {30'd0, v.exp_resp});
        check($sformatf("v%0d_rsp_rdata", idx), got_rdata, v.exp_rdata);
        check($sformatf("v%0d_rsp_timeout", idx), {31'd0, got_to}, 32'd0);
        check($sformatf("v%0d_awvalid_cycles", idx), awc, v.exp_aw);
        check($sformatf("v%0d_wvalid_cycles", idx), wc, v.exp_w);
        check($sformatf("v%0d_arvalid_cycles", idx), arc, v.exp_ar);
        check($sformatf("v%0d_ready_first_cycle", idx), rdy_first, v.exp_rdy);
        check($sformatf("v%0d_payload_stable", idx), bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] prev_rdata;
        int rsp_cnt, rdy_cnt, first_rsp;
        logic [1:0]  wd_resp;
        logic        wd_to, wd_ar;
        logic [31:0] wd_rdata;

        vecs[0] = '{write:1, b2b:0, addr:32'h4000_0008, wdat:32'h0000_0001, strb:4'hF,
                    aw_dly:0, w_dly:0, ar_dly:0, v_start:2, resp:2'b00, rdat:32'h0,
                    exp_rsp:3, exp_aw:1, exp_w:1, exp_ar:0, exp_rdy:2, exp_resp:2'b00, exp_rdata:32'h0};
        vecs[1] = '{write:1, b2b:0, addr:32'h4000_000C, wdat:32'hA5A5_5A5A, strb:4'h3,
                    aw_dly:3, w_dly:0, ar_dly:0, v_start:2, resp:2'b00, rdat:32'h0,
                    exp_rsp:6, exp_aw:4, exp_w:1, exp_ar:0, exp_rdy:5, exp_resp:2'b00, exp_rdata:32'h0};
        vecs[2] = '{write:0, b2b:0, addr:32'h4000_0004, wdat:32'h0, strb:4'h0,
                    aw_dly:0, w_dly:0, ar_dly:0, v_start:7, resp:2'b00, rdat:32'hDEAD_BEEF,
                    exp_rsp:8, exp_aw:0, exp_w:0, exp_ar:1, exp_rdy:2, exp_resp:2'b00, exp_rdata:32'hDEAD_BEEF};
        vecs[3] = '{write:0, b2b:0, addr:32'h4000_0010, wdat:32'h0, strb:4'h0,
                    aw_dly:0, w_dly:0, ar_dly:3, v_start:5, resp:2'b11, rdat:32'h1234_5678,
                    exp_rsp:6, exp_aw:0, exp_w:0, exp_ar:4, exp_rdy:5, exp_resp:2'b11, exp_rdata:32'h1234_5678};
        vecs[4] = '{write:1, b2b:0, addr:32'h4000_0020, wdat:32'hCAFE_F00D, strb:4'h9,
                    aw_dly:0, w_dly:2, ar_dly:0, v_start:4, resp:2'b11, rdat:32'h0,
                    exp_rsp:5, exp_aw:1, exp_w:3, exp_ar:0, exp_rdy:4, exp_resp:2'b11, exp_rdata:32'h1234_5678};
        vecs[5] = '{write:1, b2b:0, addr:32'h4000_0000, wdat:32'hFFFF_FFFF, strb:4'hF,
                    aw_dly:0, w_dly:0, ar_dly:0, v_start:2, resp:2'b10, rdat:32'h0,
                    exp_rsp:3, exp_aw:1, exp_w:1, exp_ar:0, exp_rdy:2, exp_resp:2'b10, exp_rdata:32'h1234_5678};
        vecs[6] = '{write:0, b2b:1, addr:32'h4000_0008, wdat:32'h0, strb:4'h0,
                    aw_dly:0, w_dly:0, ar_dly:0, v_start:2, resp:2'b00, rdat:32'h0BAD_CAFE,
                    exp_rsp:3, exp_aw:0, exp_w:0, exp_ar:1, exp_rdy:2, exp_resp:2'b00, exp_rdata:32'h0BAD_CAFE};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        slave_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_valids_readies", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("reset_rsp_valid_timeout", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_resp", {30'd0, rsp_resp}, 32'd0);

        prev_rdata = 32'h0;
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].b2b) begin
                @(negedge clk);
                check($sformatf("v%0d_gap_rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
                check($sformatf("v%0d_gap_rdata_hold", i), rsp_rdata, prev_rdata);
            end
            run_txn(vecs[i], i);
            prev_rdata = vecs[i].exp_rdata;
        end

        // Watchdog: a read whose arready never arrives.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0030;
        rsp_cnt = 0; rdy_cnt = 0; first_rsp = -1;
        wd_resp = 2'bxx; wd_to = 1'bx; wd_ar = 1'bx; wd_rdata = 32'hx;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                rsp_cnt++;
                if (first_rsp < 0) begin
                    first_rsp = t; wd_resp = rsp_resp; wd_to = rsp_timeout;
                    wd_ar = arvalid; wd_rdata = rsp_rdata;
                end
            end
            if (cmd_ready) rdy_cnt++;
        end
`ifdef UPS_AXIL_MASTER_TIMEOUT_EN
        check("wd_rsp_cycle", first_rsp, 17);
        check("wd_rsp_count", rsp_cnt, 1);
        check("wd_rsp_timeout", {31'd0, wd_to}, 32'd1);
        check("wd_rsp_resp", {30'd0, wd_resp}, 32'd2);
        check("wd_arvalid_dropped", {31'd0, wd_ar}, 32'd0);
        check("wd_rdata_hold", wd_rdata, 32'h0BAD_CAFE);
`else
        check("wd_no_rsp", rsp_cnt, 0);
        check("wd_cmd_ready_low", rdy_cnt, 0);
        check("wd_arvalid_held", {31'd0, arvalid}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wd_recover_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("wd_recover_arvalid", {31'd0, arvalid}, 32'd0);

        // Reset while waiting in WRESP.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0040;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstmid_in_wresp_bready", {31'd0, bready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_valids_readies", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        bvalid = 1'b1;
        @(negedge clk);
        check("rstmid_late_b_ignored", {31'd0, rsp_valid}, 32'd0);
        slave_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ups_axil_master.md
# ups_axil_master

AXI4-Lite initiator that turns single-beat register commands from fabric logic into AXI4-Lite read and write transactions on a `ca4l_*` bus. It is the master-side counterpart to the fabric register-bank responder. It lets PL sequencers, such as the mode controller or test logic, drive an AXI4-Lite register bank without the PS. It handles one outstanding transaction at a time.

## Interface
- `TIMEOUT`, default 1024: cycles to wait at any stalled handshake before aborting. Used only when the watchdog is compiled in. Minimum 2.
- `clk`  in  1  fabric clock. All logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE. A command is accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write byte strobes.
- `rsp_valid`  out  1  one-cycle completion pulse. There is no backpressure.
- `rsp_rdata`  out  32  read data. Holds its value until the next read completes.
- `rsp_resp`  out  2  BRESP/RRESP of the completed transaction, or 2'b10 on timeout.
- `rsp_timeout`  out  1  qualifies `rsp_valid`. High when the transaction was aborted.
- `ca4l_awaddr` out 32, `ca4l_awprot` out 3, `ca4l_awvalid` out 1, `ca4l_awready` in 1.
- `ca4l_wdata` out 32, `ca4l_wstrb` out 4, `ca4l_wvalid` out 1, `ca4l_wready` in 1.
- `ca4l_bresp` in 2, `ca4l_bvalid` in 1, `ca4l_bready` out 1.
- `ca4l_araddr` out 32, `ca4l_arprot` out 3, `ca4l_arvalid` out 1, `ca4l_arready` in 1.
- `ca4l_rdata` in 32, `ca4l_rresp` in 2, `ca4l_rvalid` in 1, `ca4l_rready` out 1.

## Operation
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA.
- **Accepting a command (IDLE):** on accept, register addr/data/strb.
  - Write: set `awvalid` and `wvalid`, go to WADDR.
  - Read: set `arvalid`, go to RADDR.
- **WADDR:** AW and W are tracked independently.
  - Each valid drops on the edge after its own handshake.
  - When both handshakes are complete, go to WRESP. This includes both completing in the same cycle.
- **WRESP:** `bready` = 1. On `bvalid`, capture `bresp`, pulse `rsp_valid`, return to IDLE.
- **RADDR:** hold `arvalid` until `arready`, then go to RDATA.
- **RDATA:** `rready` = 1. On `rvalid`, capture `rdata`/`rresp`, pulse `rsp_valid`, return to IDLE.
- **Early responses:** `bvalid`/`rvalid` arriving outside WRESP/RDATA are ignored, because `bready`/`rready` are low.
- **Constant/stable outputs:**
  - `awprot` and `arprot` are tied to 3'b000.
  - AXI address, data and strobe outputs are held stable while their valid is high.
- **Responses:** BRESP/RRESP are passed through unmodified. SLVERR and DECERR are not retried.
- **Reset values:** all valids, `bready`, `rready`, `rsp_valid`, `rsp_timeout` = 0. `rsp_rdata` = 0, `rsp_resp` = 0. State is IDLE, so `cmd_ready` = 1 in the first cycle after reset is released.
- **Reset mid-transaction:** everything returns to reset values on the next edge and no response is issued.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the state.
- **Write, zero-wait slave:**
  - Command accepted at cycle 0.
  - AW/W valid at cycle 1, handshakes at 1.
  - WRESP at 2 with `bvalid` at 2.
  - `rsp_valid` at 3.
- **Read, zero-wait slave:**
  - `arvalid` at 1, RDATA at 2 with `rvalid` at 2.
  - `rsp_valid` at 3.
- **Back-to-back commands:** the next command can be accepted in the cycle `rsp_valid` is high, giving a throughput of 1 transaction per 3 cycles at best.

## Configuration
- Macro `UPS_AXIL_MASTER_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on each state entry and on every handshake, and increments in WADDR, WRESP, RADDR and RDATA.
  - When it reaches `TIMEOUT`, all AXI valids and readies drop on the next edge.
  - In the same cycle, `rsp_valid` = 1, `rsp_timeout` = 1, `rsp_resp` = 2'b10, and the state returns to IDLE.
  - A timed-out read leaves `rsp_rdata` unchanged.
- **Undefined:**
  - No counter is built and `rsp_timeout` is tied to 0.
  - A stalled slave holds the block in its wait state indefinitely, with `cmd_ready` low.

## Test plan
- **Zero-wait write:** write 0x4000_0008 / 0x0000_0001 / strb 0xF, slave always ready, bresp 00 -> AW/W valid only at cycle 1, `rsp_valid` at cycle 3, `rsp_resp` = 00.
- **Skewed AW/W:** write with `wready` immediate and `awready` delayed 3 cycles -> `wvalid` high 1 cycle, `awvalid` high 4 cycles, `bready` rises only after both handshakes, and an early `bvalid` is not consumed.
- **Delayed read data:** read 0x4000_0004 with `rvalid` delayed 5 cycles, rdata 0xDEADBEEF -> `rsp_rdata` = 0xDEADBEEF, `rsp_resp` = 00, `arvalid` stays stable until `arready`.
- **Error passthrough:** write with bresp 2'b10 -> `rsp_resp` = 10, `rsp_timeout` = 0. Then issue a back-to-back read in the `rsp_valid` cycle -> it is accepted.
- **Watchdog:** with `TIMEOUT` = 16 and `arready` never asserted.
  - With the macro -> `rsp_valid`, `rsp_timeout` and resp 10 occur 16 cycles after RADDR entry, and `arvalid` then drops.
  - Without the macro -> no response after 100 cycles and `cmd_ready` stays 0.
- **Reset mid-transaction:** assert `rst` during WRESP -> on the next edge all valids/readies are 0, there is no `rsp_valid`, and `cmd_ready` = 1.
